// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad value-entry front end:
// FSM states, key codes and the row/column keymap.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  localparam int DIGITS    = 4;
  localparam int VALUE_W   = 12;
  localparam int MAX_VALUE = 4095;
  localparam int ACC_W     = 14;
  localparam int KEY_W     = 5;

  // Codes 0..9 are the digits themselves; the rest sit above the BCD range.
  localparam logic [KEY_W-1:0] KEY_ENTER = 5'h0A;
  localparam logic [KEY_W-1:0] KEY_BS    = 5'h0B;
  localparam logic [KEY_W-1:0] KEY_CLR   = 5'h0C;
  localparam logic [KEY_W-1:0] KEY_D     = 5'h0D;
  localparam logic [KEY_W-1:0] KEY_STAR  = 5'h10;
  localparam logic [KEY_W-1:0] KEY_HASH  = 5'h11;
  localparam logic [KEY_W-1:0] KEY_NONE  = 5'h1F;

  function automatic logic [KEY_W-1:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [KEY_W-1:0] code;
    case ({r, c})
      4'h0:    code = 5'd1;
      4'h1:    code = 5'd2;
      4'h2:    code = 5'd3;
      4'h3:    code = KEY_ENTER;
      4'h4:    code = 5'd4;
      4'h5:    code = 5'd5;
      4'h6:    code = 5'd6;
      4'h7:    code = KEY_BS;
      4'h8:    code = 5'd7;
      4'h9:    code = 5'd8;
      4'hA:    code = 5'd9;
      4'hB:    code = KEY_CLR;
      4'hC:    code = KEY_STAR;
      4'hD:    code = 5'd0;
      4'hE:    code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column driver, row synchronizer, per-sweep key decode and press/release
// debounce. Emits one key_event pulse per accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEB_CNT  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic             key_event,
  output logic [KEY_W-1:0] key_code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEB_CNT + 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       cidx_q, cidx_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       sync1_q, sync2_q;
  logic [1:0]       hits_q, hits_d;
  logic [KEY_W-1:0] hit_code_q, hit_code_d;
  logic             armed_q, armed_d;
  logic [KEY_W-1:0] deb_code_q, deb_code_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             event_q, event_d;
  logic [KEY_W-1:0] code_q, code_d;

  logic             slot_end;
  logic [1:0]       hits_n;
  logic [KEY_W-1:0] hit_code_n;
  logic [KEY_W-1:0] sweep_res;
  logic [DEB_W-1:0] run_n;

  always_comb begin
    div_d      = div_q;
    cidx_d     = cidx_q;
    hits_d     = hits_q;
    hit_code_d = hit_code_q;
    armed_d    = armed_q;
    deb_code_d = deb_code_q;
    deb_cnt_d  = deb_cnt_q;
    event_d    = 1'b0;
    code_d     = code_q;
    hits_n     = hits_q;
    hit_code_n = hit_code_q;
    sweep_res  = KEY_NONE;
    run_n      = '0;
    slot_end   = (div_q == DIV_W'(SCAN_DIV - 1));

    if (slot_end) begin
      div_d  = '0;
      cidx_d = cidx_q + 2'd1;
      // Tally pressed rows seen in this slot; hits saturates at 2 (= several keys).
      for (int r = 0; r < 4; r++) begin
        if (!sync2_q[r]) begin
          if (hits_n == 2'd0) begin
            hits_n     = 2'd1;
            hit_code_n = key_map(2'(r), cidx_q);
          end else begin
            hits_n = 2'd2;
          end
        end
      end
      if (cidx_q == 2'd3) begin
        sweep_res  = (hits_n == 2'd1) ? hit_code_n : KEY_NONE;
        hits_d     = 2'd0;
        hit_code_d = KEY_NONE;
        if (armed_q) begin
          if (sweep_res == KEY_NONE) begin
            deb_cnt_d  = '0;
            deb_code_d = KEY_NONE;
          end else begin
            run_n      = (sweep_res == deb_code_q) ? deb_cnt_q + DEB_W'(1) : DEB_W'(1);
            deb_code_d = sweep_res;
            deb_cnt_d  = run_n;
            if (int'(run_n) >= DEB_CNT) begin
              event_d    = 1'b1;
              code_d     = sweep_res;
              armed_d    = 1'b0;
              deb_cnt_d  = '0;
              deb_code_d = KEY_NONE;
            end
          end
        end else begin
          run_n     = (sweep_res == KEY_NONE) ? deb_cnt_q + DEB_W'(1) : '0;
          deb_cnt_d = run_n;
          if (int'(run_n) >= DEB_CNT) begin
            armed_d   = 1'b1;
            deb_cnt_d = '0;
          end
        end
      end else begin
        hits_d     = hits_n;
        hit_code_d = hit_code_n;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    col_d = ~(4'b0001 << cidx_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      cidx_q     <= 2'd0;
      col_q      <= 4'b1110;
      sync1_q    <= 4'hF;
      sync2_q    <= 4'hF;
      hits_q     <= 2'd0;
      hit_code_q <= KEY_NONE;
      armed_q    <= 1'b1;
      deb_code_q <= KEY_NONE;
      deb_cnt_q  <= '0;
      event_q    <= 1'b0;
      code_q     <= KEY_NONE;
    end else begin
      div_q      <= div_d;
      cidx_q     <= cidx_d;
      col_q      <= col_d;
      sync1_q    <= row;
      sync2_q    <= sync1_q;
      hits_q     <= hits_d;
      hit_code_q <= hit_code_d;
      armed_q    <= armed_d;
      deb_code_q <= deb_code_d;
      deb_cnt_q  <= deb_cnt_d;
      event_q    <= event_d;
      code_q     <= code_d;
    end
  end

  assign col       = col_q;
  assign key_event = event_q;
  assign key_code  = code_q;

endmodule

// File: rtl/keypad_value_entry.sv
// Keypad digit entry and BCD-to-binary operand conversion.
// Build option KEYPAD_SATURATE_EN clamps value to 4095 on overflow instead of wrapping.
module keypad_value_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEB_CNT  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         row,
  output logic [3:0]         col,
  output logic [VALUE_W-1:0] value,
  output logic               value_valid,
  output logic               overflow,
  output logic [15:0]        bcd_live,
  output logic               busy
);

  logic             key_event;
  logic [KEY_W-1:0] key_code;

  keypad_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DEB_CNT  (DEB_CNT)
  ) u_scanner (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_event (key_event),
    .key_code  (key_code)
  );

  function automatic logic [VALUE_W-1:0] sat_value(input logic [ACC_W-1:0] acc);
`ifdef KEYPAD_SATURATE_EN
    return (acc > ACC_W'(MAX_VALUE)) ? VALUE_W'(MAX_VALUE) : acc[VALUE_W-1:0];
`else
    return acc[VALUE_W-1:0];
`endif
  endfunction

  state_t             state_q, state_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [2:0]         count_q, count_d;
  logic               done_q, done_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [1:0]         step_q, step_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;

  logic [15:0]        entry_base;
  logic [2:0]         entry_cnt;
  logic [3:0]         cur_digit;
  logic [ACC_W-1:0]   acc_next;

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    count_d = count_q;
    done_d  = done_q;
    acc_d   = acc_q;
    step_d  = step_q;
    value_d = value_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;

    // A digit after a finished conversion starts a fresh entry.
    entry_base = done_q ? 16'h0000 : bcd_q;
    entry_cnt  = done_q ? 3'd0 : count_q;
    // Step 0 reads [15:12], step 3 reads [3:0].
    cur_digit  = bcd_q[{~step_q, 2'b00} +: 4];
    acc_next   = (acc_q << 3) + (acc_q << 1) + ACC_W'(cur_digit);

    case (state_q)
      IDLE: begin
        if (key_event) begin
          if (key_code <= KEY_W'(9)) begin
            done_d  = 1'b0;
            bcd_d   = entry_base;
            count_d = entry_cnt;
            if (entry_cnt < 3'(DIGITS)) begin
              bcd_d   = {entry_base[11:0], key_code[3:0]};
              count_d = entry_cnt + 3'd1;
            end
          end else if (key_code == KEY_BS) begin
            if (count_q != 3'd0) begin
              bcd_d   = bcd_q >> 4;
              count_d = count_q - 3'd1;
            end
          end else if (key_code == KEY_CLR) begin
            bcd_d   = 16'h0000;
            count_d = 3'd0;
            ovf_d   = 1'b0;
            done_d  = 1'b0;
          end else if (key_code == KEY_ENTER) begin
            state_d = CONVERT;
            acc_d   = '0;
            step_d  = 2'd0;
          end
        end
      end
      CONVERT: begin
        acc_d  = acc_next;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d = DONE;
          value_d = sat_value(acc_next);
          ovf_d   = (acc_next > ACC_W'(MAX_VALUE));
          valid_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bcd_q   <= 16'h0000;
      count_q <= 3'd0;
      done_q  <= 1'b0;
      acc_q   <= '0;
      step_q  <= 2'd0;
      value_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      count_q <= count_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      value_q <= value_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign overflow    = ovf_q;
  assign bcd_live    = bcd_q;
  assign busy        = busy_q;

endmodule

// File: doc/keypad_value_entry.md
# keypad_value_entry

Keypad front end for the calculator datapath: scans a 4x4 matrix keypad, debounces presses, and collects up to four decimal digits. It converts the entered BCD digits into a 12-bit binary operand for the ALU x/y inputs. It is the input-side counterpart of the binary-to-BCD / seven-segment display path, and exposes the live BCD digits so the display mux can echo entry.

## Interface

**Parameters**
- SCAN_DIV, default 1000: clk cycles each column is driven.
- DEB_CNT, default 4: consecutive identical full sweeps needed to accept a press or a release.

**Ports**
- clk, input, 1: single clock. All logic is updated on the rising edge.
- reset, input, 1: asynchronous, active-high. Clears all state.
- row, input, 4: keypad rows. Active-low, with external pull-ups.
- col, output, 4: keypad columns. Active-low; exactly one bit is low at a time.
- value, output, 12: converted binary operand.
- value_valid, output, 1: one-cycle pulse when value updates.
- overflow, output, 1: the last conversion exceeded 4095. Held until the next conversion or a clear.
- bcd_live, output, 16: entered digits, with the newest digit at [3:0].
- busy, output, 1: high during CONVERT and DONE.

## Operation

**Reset values:** col=4'b1110, value=0, value_valid=0, overflow=0, bcd_live=0, busy=0, digit count=0.

**Keymap** (row r, col c), by row:
- Row 0: 1, 2, 3, A
- Row 1: 4, 5, 6, B
- Row 2: 7, 8, 9, C
- Row 3: *, 0, #, D

Key roles:
- A = enter.
- B = backspace.
- C = clear.
- *, #, D = ignored.

**Scan**
- Columns 0..3 are driven low in turn, each for SCAN_DIV cycles.
- row passes through a 2-flop synchronizer and is sampled on the last cycle of each slot.
- One sweep = 4 slots. The sweep result is one of: none, one key, or multiple keys. Multiple keys is treated as none.

**Debounce**
- A press event requires DEB_CNT consecutive sweeps with the same single key, starting from the released state.
- Re-arming requires DEB_CNT consecutive sweeps of none.
- Each press produces exactly one event; there is no auto-repeat.

**Entry, in IDLE**
- Digit:
  - If the previous conversion completed, bcd_live is first cleared and count set to 0 (fresh entry).
  - If count<4: shift the digit in at [3:0] and increment count. If count=4, the press is ignored.
- Backspace: shift bcd_live right by 4 and decrement count. No-op when count=0.
- Clear: bcd_live=0, count=0, overflow=0.
- Enter: go to CONVERT. Enter with count=0 converts 0.
- Every key event while busy is dropped.

**FSM:** IDLE → CONVERT (exactly 4 cycles) → DONE (1 cycle) → IDLE.

**CONVERT**
- Uses a 14-bit accumulator, acc = (acc<<3)+(acc<<1)+digit.
- Digits are consumed from the most significant, [15:12], first. Leading zeros are included.

**DONE**
- Drives value_valid=1 for one cycle.
- overflow = (acc>4095).
- value as selected under Configuration.
- bcd_live is retained for display until the next digit press.

## Timing
- Let cycle T be the cycle in which the enter event is registered.
  - CONVERT spans T+1..T+4.
  - value, overflow and value_valid all update at T+5, with value_valid high for that cycle only.
  - busy is high from T+1 through T+5.
- Press latency: at most 4·SCAN_DIV·(DEB_CNT+1)+2 cycles from a stable key to the event.
- Reset asserted mid-scan or mid-conversion: everything returns to reset values immediately, and no value_valid is produced.
- The column counter wraps 3→0 with no idle slot in between.

## Configuration
- KEYPAD_SATURATE_EN defined: when acc>4095, value=4095.
- Undefined: value=acc[11:0], i.e. acc modulo 4096.
- overflow is asserted identically in both builds.

## Structure
- Package keypad_pkg holds:
  - The FSM state enum (IDLE, CONVERT, DONE).
  - Key code constants KEY_ENTER, KEY_BS, KEY_CLR, KEY_NONE.
  - DIGITS=4, VALUE_W=12, MAX_VALUE=4095.
  - The row/col-to-code keymap function.
- Sub-module keypad_scanner contains the column driver, synchronizer, sweep decode and debounce. It outputs key_event (pulse) and key_code.
- The top level holds the entry register, the FSM and the accumulator.

## Test plan
All scenarios use SCAN_DIV=4, DEB_CNT=2, with a keypad model that pulls a row low when its column is driven.
- **Reset:** col=1110 and all outputs 0. Columns cycle 1110→1101→1011→0111→1110, each held 4 cycles.
- **Normal entry:** 1,2,3,4,A → bcd_live=16'h1234 and value=1234 (12'h4D2). value_valid is a single pulse 5 cycles after the enter event; overflow=0.
- **Overflow:** 9,9,9,9,A → overflow=1 and value=4095 with KEYPAD_SATURATE_EN; value=1807 without it.
- **Debounce:** key 5 held for 10 sweeps → exactly one digit entered. Key 5 toggled every sweep → no event. Keys 1 and 2 held together → no event.
- **Editing:** 7,8,B → bcd_live=16'h0007; C → 0. Then 1,2,3,4,5 → 16'h1234, with the fifth digit ignored. A digit pressed after a completed conversion restarts entry at 16'h000d.
- **Reset during conversion:** reset asserted at T+2 → no value_valid, value=0, bcd_live=0. A key pressed while busy is dropped.
